cntr8_arb_ctrl: RTL and testbench

- Two-requester command controller and arbiter for the shared 8-bit loadable up-counter datapath.
- Accepts LOAD / INC-by-N / READ / CLEAR commands from two clients and arbitrates them round-robin.
- Sequences the counter's load/inc strobes and returns the settled counter value with a done pulse.
- Sits between the client logic and the counter instance; it is the only driver of the counter's load/inc/d_in.

---
 rtl/cntr8_arb_ctrl.sv | 134 +++++++++++++
 tb/tb_cntr8_arb_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cntr8_arb_ctrl.sv
// Two-client round-robin command controller driving a shared loadable up-counter.
// Optional INC saturation at all-ones is enabled by defining CNTR8_ARB_CTRL_SAT_EN.
module cntr8_arb_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_load,
    output logic             cnt_inc,
    output logic [WIDTH-1:0] cnt_d,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rdata,
    output logic             sat
);

`ifdef CNTR8_ARB_CTRL_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, EXEC, SETTLE, DONE} state_t;
    typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_INC = 2'b01, OP_READ = 2'b10, OP_CLEAR = 2'b11} op_t;
    typedef struct packed {
        op_t              op;
        logic [WIDTH-1:0] data;
    } cmd_t;

    state_t           state;
    cmd_t             cmd;
    cmd_t             sel_cmd;
    logic [WIDTH-1:0] rem;
    logic             last;
    logic             pick;
    logic             sat_hit;
    logic [WIDTH:0]   next_val;
    logic             at_top;

    assign busy = (state != IDLE);

    always_comb begin
        pick    = (req == 2'b11) ? ~last : req[1];
        sel_cmd = pick ? cmd_t'{op_t'(op1), data1} : cmd_t'{op_t'(op0), data0};
    end

    // Value the counter will hold once the strobe issued this cycle lands.
    always_comb begin
        next_val = {1'b0, cnt_q} + {{WIDTH{1'b0}}, cnt_inc};
        at_top   = SAT_EN && (next_val == {1'b0, {WIDTH{1'b1}}});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cmd      <= '0;
            rem      <= '0;
            last     <= 1'b1;
            gnt      <= 2'b00;
            cnt_load <= 1'b0;
            cnt_inc  <= 1'b0;
            cnt_d    <= '0;
            done     <= 1'b0;
            rdata    <= '0;
            sat      <= 1'b0;
            sat_hit  <= 1'b0;
        end else begin
            cnt_load <= 1'b0;
            cnt_inc  <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: if (req != 2'b00) begin
                    cmd   <= sel_cmd;
                    gnt   <= pick ? 2'b10 : 2'b01;
                    state <= EXEC;
                    case (sel_cmd.op)
                        OP_LOAD: begin
                            cnt_load <= 1'b1;
                            cnt_d    <= sel_cmd.data;
                        end
                        OP_CLEAR: begin
                            cnt_load <= 1'b1;
                            cnt_d    <= '0;
                        end
                        OP_INC: if (sel_cmd.data != '0) begin
                            if (at_top) sat_hit <= 1'b1;
                            else begin
                                cnt_inc <= 1'b1;
                                rem     <= sel_cmd.data;
                            end
                        end
                        default: ;
                    endcase
                end
                // rem counts pulses still owed including the one on the bus now.
                EXEC: if (cmd.op == OP_INC && rem > WIDTH'(1)) begin
                    if (at_top) begin
                        sat_hit <= 1'b1;
                        rem     <= '0;
                        state   <= SETTLE;
                    end else begin
                        cnt_inc <= 1'b1;
                        rem     <= rem - WIDTH'(1);
                    end
                end else begin
                    rem   <= '0;
                    state <= SETTLE;
                end
                SETTLE: begin
                    rdata <= cnt_q;
                    done  <= 1'b1;
                    sat   <= sat_hit;
                    state <= DONE;
                end
                DONE: begin
                    gnt     <= 2'b00;
                    last    <= gnt[1];
                    sat     <= 1'b0;
                    sat_hit <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cntr8_arb_ctrl.sv
// Bench for cntr8_arb_ctrl: transaction-level model expanded into per-cycle expectations,
// directed scenarios with literal expectations, then randomized traffic and resets.
module tb_cntr8_arb_ctrl;

`ifdef CNTR8_ARB_CTRL_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req = 2'b00, op0 = 2'b00, op1 = 2'b00;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic [7:0] cnt_q, cnt_d, rdata;
    logic       cnt_load, cnt_inc, busy, done, sat;
    logic [1:0] gnt;
    logic [7:0] ctr = 8'h00;

    int checks = 0;
    int fails  = 0;

    cntr8_arb_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .req(req), .op0(op0), .op1(op1),
        .data0(data0), .data1(data1), .cnt_q(cnt_q),
        .cnt_load(cnt_load), .cnt_inc(cnt_inc), .cnt_d(cnt_d),
        .gnt(gnt), .busy(busy), .done(done), .rdata(rdata), .sat(sat)
    );

    always #5 clk = ~clk;

    // The counter being controlled.
    assign cnt_q = ctr;
    always @(posedge clk) begin
        if (cnt_load) ctr <= cnt_d;
        else if (cnt_inc) ctr <= ctr + 8'd1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0] gnt;
        logic       busy, load, inc, done, sat;
        logic [7:0] d, rdata;
    } exp_t;

    exp_t       q[$];
    bit         chk_en = 1'b0;
    bit         m_last = 1'b1;
    logic [7:0] m_cnt = 8'h00;
    logic [7:0] m_rdata = 8'h00;

    // Model: when a request is seen in an idle cycle, the whole command is expanded into
    // the outputs expected on each following cycle, computed from arithmetic on the count.
    always @(negedge clk) begin
        exp_t       e;
        bit         idle, c, s;
        logic [1:0] op;
        logic [7:0] n, fin;
        int         pulses, len;
        idle = (q.size() == 0);
        if (idle) e = '{gnt: 2'b00, busy: 1'b0, load: 1'b0, inc: 1'b0, done: 1'b0,
                        sat: 1'b0, d: 8'h00, rdata: m_rdata};
        else e = q.pop_front();
        if (chk_en) begin
            chk("gnt", gnt, e.gnt);
            chk("busy", busy, e.busy);
            chk("cnt_load", cnt_load, e.load);
            chk("cnt_inc", cnt_inc, e.inc);
            chk("done", done, e.done);
            chk("sat", sat, e.sat);
            chk("rdata", rdata, e.rdata);
            if (e.load) chk("cnt_d", cnt_d, e.d);
        end
        if (e.load) m_cnt = e.d;
        else if (e.inc) m_cnt = m_cnt + 8'd1;
        if (reset) begin
            q.delete();
            chk_en  = 1'b1;
            m_last  = 1'b1;
            m_rdata = 8'h00;
        end else if (idle && chk_en && req != 2'b00) begin
            c      = (req == 2'b11) ? !m_last : req[1];
            op     = c ? op1 : op0;
            n      = c ? data1 : data0;
            s      = 1'b0;
            pulses = 0;
            case (op)
                2'b00: fin = n;
                2'b01: begin
                    pulses = int'(n);
                    if (SAT && int'(n) > 255 - int'(m_cnt)) begin
                        pulses = 255 - int'(m_cnt);
                        s = 1'b1;
                    end
                    fin = 8'(int'(m_cnt) + pulses);
                end
                2'b10: fin = m_cnt;
                default: fin = 8'h00;
            endcase
            len = (pulses > 1) ? pulses : 1;
            for (int k = 1; k <= len; k++)
                q.push_back('{gnt: c ? 2'b10 : 2'b01, busy: 1'b1,
                              load: (op == 2'b00 || op == 2'b11) && k == 1,
                              inc: k <= pulses, done: 1'b0, sat: 1'b0,
                              d: (op == 2'b11) ? 8'h00 : n, rdata: m_rdata});
            q.push_back('{gnt: c ? 2'b10 : 2'b01, busy: 1'b1, load: 1'b0, inc: 1'b0,
                          done: 1'b0, sat: 1'b0, d: 8'h00, rdata: m_rdata});
            q.push_back('{gnt: c ? 2'b10 : 2'b01, busy: 1'b1, load: 1'b0, inc: 1'b0,
                          done: 1'b1, sat: s, d: 8'h00, rdata: fin});
            m_rdata = fin;
            m_last  = c;
        end
    end

    // One command from an idle controller, with hand-computed expectations.
    task automatic run_cmd(input string nm, input int c, input logic [1:0] op, input logic [7:0] d,
                           input logic [7:0] exp_rd, input int exp_lat, input int exp_pulses,
                           input bit exp_sat);
        int n = 0, pulses = 0, gcyc = 0;
        bit seen = 1'b0;
        logic [1:0] g = (c == 0) ? 2'b01 : 2'b10;
        if (c == 0) begin req[0] = 1'b1; op0 = op; data0 = d; end
        else        begin req[1] = 1'b1; op1 = op; data1 = d; end
        while (n < 300 && !seen) begin
            @(posedge clk); #1;
            n++;
            if (cnt_inc) pulses++;
            if (gnt == g) gcyc++;
            if (done) seen = 1'b1;
        end
        chk({nm, " done_seen"}, seen, 1'b1);
        chk({nm, " latency"}, n, exp_lat);
        chk({nm, " gnt_cycles"}, gcyc, exp_lat);
        chk({nm, " pulses"}, pulses, exp_pulses);
        chk({nm, " rdata"}, rdata, exp_rd);
        chk({nm, " sat"}, sat, exp_sat);
        req[c] = 1'b0;
        @(posedge clk); #1;
        chk({nm, " busy_after"}, busy, 1'b0);
        chk({nm, " gnt_after"}, gnt, 2'b00);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 2'b00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic rand_cmd(output logic [1:0] op, output logic [7:0] d);
        op = 2'($urandom_range(0, 3));
        if (op == 2'b01) d = 8'($urandom_range(0, 7));
        else if ($urandom_range(0, 2) == 0) d = 8'hF8 + 8'($urandom_range(0, 7));
        else d = 8'($urandom);
    endtask

    initial begin
        logic [1:0] gseq[$];
        logic [1:0] prev;
        logic [1:0] rop;
        logic [7:0] rd;
        do_reset();
        chk("reset gnt", gnt, 2'b00);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset rdata", rdata, 8'h00);
        chk("reset cnt_load", cnt_load, 1'b0);
        chk("reset cnt_inc", cnt_inc, 1'b0);
        chk("reset sat", sat, 1'b0);

        run_cmd("load5a", 0, 2'b00, 8'h5A, 8'h5A, 3, 0, 1'b0);
        run_cmd("load10", 0, 2'b00, 8'h10, 8'h10, 3, 0, 1'b0);
        run_cmd("inc3", 0, 2'b01, 8'd3, 8'h13, 5, 3, 1'b0);
        run_cmd("load44", 1, 2'b00, 8'h44, 8'h44, 3, 0, 1'b0);
        run_cmd("inc0", 0, 2'b01, 8'd0, 8'h44, 3, 0, 1'b0);
        run_cmd("clear", 1, 2'b11, 8'h77, 8'h00, 3, 0, 1'b0);
        run_cmd("loadfe", 0, 2'b00, 8'hFE, 8'hFE, 3, 0, 1'b0);
        run_cmd("inc4_top", 0, 2'b01, 8'd4, SAT ? 8'hFF : 8'h02, SAT ? 3 : 6, SAT ? 1 : 4, SAT);

        // Both clients READ continuously: grants must alternate starting with client 0.
        do_reset();
        op0 = 2'b10; op1 = 2'b10; req = 2'b11;
        prev = 2'b00;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (gnt != 2'b00 && prev == 2'b00) gseq.push_back(gnt);
            prev = gnt;
        end
        req = 2'b00;
        repeat (6) @(posedge clk);
        #1;
        chk("rr count", gseq.size() >= 4, 1'b1);
        if (gseq.size() >= 4) begin
            chk("rr g0", gseq[0], 2'b01);
            chk("rr g1", gseq[1], 2'b10);
            chk("rr g2", gseq[2], 2'b01);
            chk("rr g3", gseq[3], 2'b10);
        end

        // Reset on the 5th EXEC cycle of a long INC, then a READ sees the partial count.
        run_cmd("load00", 0, 2'b00, 8'h00, 8'h00, 3, 0, 1'b0);
        req[0] = 1'b1; op0 = 2'b01; data0 = 8'd200;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1; req = 2'b00;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst gnt", gnt, 2'b00);
        chk("midrst cnt_inc", cnt_inc, 1'b0);
        chk("midrst busy", busy, 1'b0);
        chk("midrst done", done, 1'b0);
        chk("midrst rdata", rdata, 8'h00);
        run_cmd("read5", 0, 2'b10, 8'h00, 8'h05, 3, 0, 1'b0);

        // Random traffic; opcode scrambles after grant must be ignored.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 199) == 0) reset = 1'b1;
            for (int c = 0; c < 2; c++) begin
                if (req[c] && gnt[c] && done) begin
                    if ($urandom_range(0, 3) != 0) req[c] = 1'b0;
                end else if (!req[c] && $urandom_range(0, 2) == 0) begin
                    rand_cmd(rop, rd);
                    req[c] = 1'b1;
                    if (c == 0) begin op0 = rop; data0 = rd; end
                    else        begin op1 = rop; data1 = rd; end
                end else if (gnt[c] && $urandom_range(0, 3) == 0) begin
                    rand_cmd(rop, rd);
                    if (c == 0) begin op0 = rop; data0 = rd; end
                    else        begin op1 = rop; data1 = rd; end
                end
            end
        end
        reset = 1'b0;
        req = 2'b00;
        repeat (20) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
